// File: rtl/prf_pkg.sv
// rtl/prf_pkg.sv - default sizing constants and helpers for the physical register file scoreboard
package prf_pkg;

    localparam int PRF_DEPTH  = 48;
    localparam int PRF_WIDTH  = 32;
    localparam int PRF_AW     = 6;
    localparam int PRF_NUM_RD = 8;
    localparam int PRF_NUM_WR = 1;

    function automatic int prf_clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((64'(1) << r) < 64'(value)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prf_read_port.sv
// rtl/prf_read_port.sv - one read port: address qualification, CDB bypass and optional output register
module prf_read_port
    import prf_pkg::*;
#(
    parameter int DEPTH    = PRF_DEPTH,
    parameter int WIDTH    = PRF_WIDTH,
    parameter int AW       = PRF_AW,
    parameter int NUM_WR   = PRF_NUM_WR,
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    input  logic [WIDTH-1:0]        mem_data_i,
    input  logic                    mem_ready_i,
    input  logic [NUM_WR-1:0]       wr_en_i,
    input  logic [NUM_WR*AW-1:0]    wr_addr_i,
    input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic                    rd_ready_o
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             ready_d, ready_q;

    always_comb begin
        data_d  = '0;
        ready_d = 1'b1;
        if (!rd_en_i) begin
            ready_d = 1'b1;
        end else if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            ready_d = 1'b1;
        end else if (int'(rd_addr_i) >= DEPTH) begin
            ready_d = 1'b0;
        end else begin
            data_d  = mem_data_i;
            ready_d = mem_ready_i;
            // Ascending scan: a later (higher-index) matching write port overrides earlier ones.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i)) begin
                    data_d  = wr_data_i[w*WIDTH +: WIDTH];
                    ready_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign rd_data_o  = (READ_REG != 0) ? data_q  : data_d;
    assign rd_ready_o = (READ_REG != 0) ? ready_q : ready_d;

endmodule

// File: rtl/prf_scoreboard.sv
// rtl/prf_scoreboard.sv - parametrised physical register file with per-register ready scoreboard
module prf_scoreboard
    import prf_pkg::*;
#(
    parameter int DEPTH    = PRF_DEPTH,
    parameter int WIDTH    = PRF_WIDTH,
    parameter int AW       = PRF_AW,
    parameter int NUM_RD   = PRF_NUM_RD,
    parameter int NUM_WR   = PRF_NUM_WR,
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_ready,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic                    alloc_en,
    input  logic [AW-1:0]           alloc_addr,
    output logic                    wr_collision
);

    if (AW < prf_clog2(DEPTH)) begin : g_aw_check
        $error("prf_scoreboard: AW too small for DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] rdy_q, rdy_d;
    logic             coll_q, coll_d;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        mem_d  = mem_q;
        rdy_d  = rdy_q;
        coll_d = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && addr_ok(wr_addr[w*AW +: AW])) begin
                mem_d[wr_addr[w*AW +: AW]] = wr_data[w*WIDTH +: WIDTH];
                rdy_d[wr_addr[w*AW +: AW]] = 1'b1;
            end
        end
        // Alloc is applied after writes so a same-cycle write cannot leave the register ready.
        if (alloc_en && addr_ok(alloc_addr)) begin
            rdy_d[alloc_addr] = 1'b0;
        end
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en[i] && wr_en[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
                    coll_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            rdy_q  <= '1;
            coll_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            rdy_q  <= rdy_d;
            coll_q <= coll_d;
        end
    end

    assign wr_collision = coll_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]    port_addr;
        logic [WIDTH-1:0] port_mem_data;
        logic             port_mem_rdy;

        assign port_addr = rd_addr[g*AW +: AW];

        always_comb begin
            port_mem_data = '0;
            port_mem_rdy  = 1'b0;
            if (int'(port_addr) < DEPTH) begin
                port_mem_data = mem_q[port_addr];
                port_mem_rdy  = rdy_q[port_addr];
            end
        end

        prf_read_port #(
            .DEPTH    (DEPTH),
            .WIDTH    (WIDTH),
            .AW       (AW),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG),
            .READ_REG (READ_REG)
        ) u_rd (
            .clk         (clk),
            .reset       (reset),
            .rd_en_i     (rd_en[g]),
            .rd_addr_i   (port_addr),
            .mem_data_i  (port_mem_data),
            .mem_ready_i (port_mem_rdy),
            .wr_en_i     (wr_en),
            .wr_addr_i   (wr_addr),
            .wr_data_i   (wr_data),
            .rd_data_o   (rd_data[g*WIDTH +: WIDTH]),
            .rd_ready_o  (rd_ready[g])
        );
    end

endmodule

// File: doc/prf_scoreboard.md
Name: prf_scoreboard

Overview:
Parametrised successor to the 48x32 physical register file.
- Generalises depth, width and read/write port counts.
- Adds a per-register ready (scoreboard) bit, an allocation port that marks a register busy, and an optional registered-read pipeline stage.
- Sits between the rename/dispatch stage, the issue queues (int/mult/div/LSQ/store buffer) and one or more CDB write-back buses.

Parameters:
DEPTH, 48, number of physical registers (addresses 0..DEPTH-1)
WIDTH, 32, data width in bits
AW, 6, address width; must satisfy 2**AW >= DEPTH
NUM_RD, 8, number of read ports
NUM_WR, 1, number of write (CDB) ports
ZERO_REG, 1, 1: address 0 hardwired to data 0 and always ready
READ_REG, 0, 0: combinational read; 1: read data/ready registered (1-cycle latency)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*AW  packed read addresses, port i at slice i
rd_data  out  NUM_RD*WIDTH  packed read data
rd_ready  out  NUM_RD  ready bit of the addressed register
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  packed write addresses
wr_data  in  NUM_WR*WIDTH  packed write data
alloc_en  in  1  rename allocates a new destination register
alloc_addr  in  AW  register to mark not-ready
wr_collision  out  1  registered flag: two enabled write ports targeted the same address in the previous cycle

Behaviour:
Reset (asynchronous, active-high):
- All data cleared to 0 and all ready bits set to 1.
- rd_data = 0, rd_ready = 0 when READ_REG=1 (output regs cleared).
- wr_collision = 0.

Write:
- On the rising edge, each enabled port writes data[wr_addr] and sets ready[wr_addr] = 1.
- Several ports hitting the same address: the highest-index port wins. wr_collision = 1 in the next cycle and only that cycle.
- Writes to address 0 are ignored when ZERO_REG=1.
- Out-of-range addresses (>= DEPTH) are ignored.

Alloc:
- alloc_en clears ready[alloc_addr] at the edge.
- Alloc and write to the same address in the same cycle: data is written, but ready ends 0 (alloc wins).
- alloc to address 0 with ZERO_REG=1 is ignored.

Read port i, resolved in this priority order:
- !rd_en[i], or (ZERO_REG and addr==0), or addr>=DEPTH: data 0, ready 1 (ready 0 for an out-of-range address).
- Else if any enabled write port matches addr (highest-index match wins): data = wr_data of that port, ready = 1 (bypass).
- Else: data = mem[addr], ready = ready[addr].
- Same-cycle alloc does not affect the value read this cycle.

Latency:
- READ_REG=0: outputs combinational, as in the existing PRF.
- READ_REG=1: the resolved value above is captured at the edge and presented the following cycle. No bypass from the next cycle's writes.

Reset asserted mid-operation clears state immediately, regardless of the clock.

Decomposition:
- prf_pkg: default DEPTH/WIDTH/AW/port-count constants and a clog2 helper for AW checking.
- Sub-module prf_read_port: one address decode + bypass mux + optional output register. Instantiated NUM_RD times in a generate loop.
- Storage, the ready array and write/alloc logic stay in the top.

Test Plan:
1. Reset mid-run: after writes, assert reset asynchronously between edges -> rd_data 0 and ready 1 for all addresses before the next edge.
2. Write p0 addr 5 = 0xDEADBEEF, read port 3 addr 5 in the same cycle (READ_REG=0) -> rd_data 0xDEADBEEF, rd_ready 1. Next cycle, no write -> still 0xDEADBEEF.
3. alloc addr 7 -> next cycle rd_ready 0 for addr 7. Then write addr 7 = 0x12 -> bypass ready 1 / data 0x12 that cycle, and stored after the edge.
4. NUM_WR=2: p0 and p1 both write addr 9 (0xA, 0xB) -> mem[9]=0xB and wr_collision=1 for exactly one cycle.
5. Write addr 0 = 0xFFFF with ZERO_REG=1; alloc addr 0 -> reads of addr 0 return 0, ready 1.
6. READ_REG=1: write addr 4 = 0x55 while reading addr 4 -> output 0x55/ready 1 appears one cycle later. Disabled rd_en -> 0/ready 1 one cycle later.
